// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central hazard sequencer for a 5-stage pipeline. Turns
//               load-use, memory-stall, branch-redirect and trap events into
//               per-stage hold/clear controls and a PC hold. A small squash
//               FSM tracks a fetch that was in flight when the PC was
//               redirected, so its response can be discarded. It drives only
//               control signals, never data.
// Ports       : clk, rst            clock / synchronous active-high reset
//               i_if_busy           fetch outstanding, IF output not valid
//               i_mem_busy          data access in MEM not complete
//               i_id_rs1/rs2(_ren)  ID source register indices and read enables
//               i_ex_valid/is_load  EX holds a valid instruction / a load
//               i_ex_rd             EX destination register index
//               i_ex_redirect       taken branch/jump resolved in EX
//               i_trap              exception/mret redirect raised from MEM
//               o_*_hold/o_*_clear  per-stage hold and bubble controls
//               o_pc_hold           freeze the PC
//               o_fetch_squash      discard the in-flight fetch response
//               o_stall_cnt         saturating count of PC-hold cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_if_busy,
    input  logic             i_mem_busy,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_ren,
    input  logic             i_id_rs2_ren,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_load,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_redirect,
    input  logic             i_trap,
    output logic             o_pc_hold,
    output logic             o_if_id_hold,
    output logic             o_if_id_clear,
    output logic             o_id_ex_hold,
    output logic             o_id_ex_clear,
    output logic             o_ex_mem_hold,
    output logic             o_ex_mem_clear,
    output logic             o_mem_wb_clear,
    output logic             o_fetch_squash,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [0:0]       c_S_IDLE   = 1'b0;
    localparam logic [0:0]       c_S_SQUASH = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_load_use;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_load_use = i_ex_valid & i_ex_is_load & (i_ex_rd != 5'd0) &
                        ((i_id_rs1_ren & (i_id_rs1 == i_ex_rd)) |
                         (i_id_rs2_ren & (i_id_rs2 == i_ex_rd)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and stage controls
    always_comb begin
        w_state_nxt    = r_state;
        o_pc_hold      = 1'b0;
        o_if_id_hold   = 1'b0;
        o_if_id_clear  = 1'b0;
        o_id_ex_hold   = 1'b0;
        o_id_ex_clear  = 1'b0;
        o_ex_mem_hold  = 1'b0;
        o_ex_mem_clear = 1'b0;
        o_mem_wb_clear = 1'b0;
        o_fetch_squash = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                // A redirect held back by a memory stall does not move the PC
                // yet, so only a redirect that takes effect arms the squash.
                if ((i_trap | (i_ex_redirect & ~i_mem_busy)) & i_if_busy) begin
                    w_state_nxt = c_S_SQUASH;
                end
            end
            c_S_SQUASH: begin
                // The stale response lands on the first not-busy cycle and is
                // dropped that same cycle; a trap here does not extend it.
                if (~i_if_busy) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase

        if (rst) begin
            // Flush every stage on the reset cycle, whatever the inputs are.
            o_if_id_clear  = 1'b1;
            o_id_ex_clear  = 1'b1;
            o_ex_mem_clear = 1'b1;
            o_mem_wb_clear = 1'b1;
        end else begin
            o_fetch_squash = (r_state == c_S_SQUASH);
            if (i_trap) begin
                // The trapping op suppresses its own retirement in MEM.
                o_if_id_clear  = 1'b1;
                o_id_ex_clear  = 1'b1;
                o_ex_mem_clear = 1'b1;
            end else if (i_mem_busy) begin
                // Freeze everything up to MEM; EX re-presents any redirect or
                // load-use next cycle, so those are simply deferred.
                o_pc_hold      = 1'b1;
                o_if_id_hold   = 1'b1;
                o_id_ex_hold   = 1'b1;
                o_ex_mem_hold  = 1'b1;
                o_mem_wb_clear = 1'b1;
            end else if (r_state == c_S_SQUASH) begin
                // PC already holds the redirect target; wait for the stale
                // response while keeping IF/ID empty.
                o_pc_hold     = 1'b1;
                o_if_id_clear = 1'b1;
                o_id_ex_clear = i_ex_redirect | w_load_use;
            end else if (i_ex_redirect) begin
                o_if_id_clear = 1'b1;
                o_id_ex_clear = 1'b1;
            end else if (w_load_use) begin
                o_pc_hold     = 1'b1;
                o_if_id_hold  = 1'b1;
                o_id_ex_clear = 1'b1;
            end else if (i_if_busy) begin
                o_pc_hold     = 1'b1;
                o_if_id_clear = 1'b1;
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (o_pc_hold && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl: a vector table,
//               directed multi-cycle sequences and random traffic, all
//               compared against a behavioural model of the hazard rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst;
        logic       if_busy;
        logic       mem_busy;
        logic [4:0] rs1;
        logic       r1en;
        logic [4:0] rs2;
        logic       r2en;
        logic       exv;
        logic       exl;
        logic [4:0] rd;
        logic       redir;
        logic       trap;
    } in_t;

    // Output bit order: pc_hold, if_id_hold, if_id_clear, id_ex_hold,
    // id_ex_clear, ex_mem_hold, ex_mem_clear, mem_wb_clear, fetch_squash
    typedef struct packed {
        in_t        in;
        logic [8:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_busy, mem_busy, rs1_ren, rs2_ren;
    logic             ex_valid, ex_is_load, ex_redirect, trap;
    logic [4:0]       rs1, rs2, ex_rd;
    logic             pc_hold, if_id_hold, if_id_clear, id_ex_hold, id_ex_clear;
    logic             ex_mem_hold, ex_mem_clear, mem_wb_clear, fetch_squash;
    logic [CNT_W-1:0] stall_cnt;
    logic [8:0]       outs;

    int  total = 0;
    int  bad   = 0;
    bit  m_sq;
    int  m_cnt;
    vec_t tbl[15];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_if_busy      (if_busy),
        .i_mem_busy     (mem_busy),
        .i_id_rs1       (rs1),
        .i_id_rs2       (rs2),
        .i_id_rs1_ren   (rs1_ren),
        .i_id_rs2_ren   (rs2_ren),
        .i_ex_valid     (ex_valid),
        .i_ex_is_load   (ex_is_load),
        .i_ex_rd        (ex_rd),
        .i_ex_redirect  (ex_redirect),
        .i_trap         (trap),
        .o_pc_hold      (pc_hold),
        .o_if_id_hold   (if_id_hold),
        .o_if_id_clear  (if_id_clear),
        .o_id_ex_hold   (id_ex_hold),
        .o_id_ex_clear  (id_ex_clear),
        .o_ex_mem_hold  (ex_mem_hold),
        .o_ex_mem_clear (ex_mem_clear),
        .o_mem_wb_clear (mem_wb_clear),
        .o_fetch_squash (fetch_squash),
        .o_stall_cnt    (stall_cnt)
    );

    assign outs = {pc_hold, if_id_hold, if_id_clear, id_ex_hold, id_ex_clear,
                   ex_mem_hold, ex_mem_clear, mem_wb_clear, fetch_squash};

    function automatic in_t mk(bit r, bit ifb, bit mb, int s1, bit e1, int s2, bit e2,
                               bit v, bit ld, int d, bit rdr, bit tr);
        in_t x;
        x.rst = r;  x.if_busy = ifb; x.mem_busy = mb;
        x.rs1 = 5'(s1); x.r1en = e1; x.rs2 = 5'(s2); x.r2en = e2;
        x.exv = v;  x.exl = ld; x.rd = 5'(d); x.redir = rdr; x.trap = tr;
        return x;
    endfunction

    // Behavioural reference: the event with the highest priority decides.
    function automatic logic [8:0] model_out(in_t x, bit sq);
        bit lu;
        bit p, ih, ic, eh, ec, mh, mc, wc;
        p = 0; ih = 0; ic = 0; eh = 0; ec = 0; mh = 0; mc = 0; wc = 0;
        lu = x.exv && x.exl && x.rd != 0 &&
             ((x.r1en && x.rs1 == x.rd) || (x.r2en && x.rs2 == x.rd));
        if (x.rst) begin
            return 9'b001010110;
        end
        if (x.trap)               begin ic = 1; ec = 1; mc = 1; end
        else if (x.mem_busy)      begin p = 1; ih = 1; eh = 1; mh = 1; wc = 1; end
        else if (sq)              begin p = 1; ic = 1; ec = x.redir || lu; end
        else if (x.redir)         begin ic = 1; ec = 1; end
        else if (lu)              begin p = 1; ih = 1; ec = 1; end
        else if (x.if_busy)       begin p = 1; ic = 1; end
        return {p, ih, ic, eh, ec, mh, mc, wc, sq};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, compare at the falling edge, advance model at the rise.
    task automatic step(input in_t x, input bit use_exp, input logic [8:0] exp,
                        input string name);
        logic [8:0] m;
        rst = x.rst; if_busy = x.if_busy; mem_busy = x.mem_busy;
        rs1 = x.rs1; rs1_ren = x.r1en; rs2 = x.rs2; rs2_ren = x.r2en;
        ex_valid = x.exv; ex_is_load = x.exl; ex_rd = x.rd;
        ex_redirect = x.redir; trap = x.trap;
        @(negedge clk);
        m = model_out(x, m_sq);
        chk({name, "/model"}, int'(outs), int'(m));
        if (use_exp) chk({name, "/table"}, int'(outs), int'(exp));
        chk({name, "/cnt"}, int'(stall_cnt), m_cnt);
        @(posedge clk);
        if (x.rst) begin
            m_sq  = 0;
            m_cnt = 0;
        end else begin
            if (m[8] && m_cnt < CNT_MAX) m_cnt++;
            if (m_sq) m_sq = x.if_busy;
            else      m_sq = (x.trap || (x.redir && !x.mem_busy)) && x.if_busy;
        end
        #1;
    endtask

    in_t z;

    initial begin
        z = mk(0,0,0, 0,0,0,0, 0,0,0, 0,0);
        rst = 1'b1; if_busy = 0; mem_busy = 0; rs1 = 0; rs2 = 0; rs1_ren = 0;
        rs2_ren = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_redirect = 0; trap = 0;
        @(posedge clk); #1;
        m_sq = 0; m_cnt = 0;

        //                rst ifb mb rs1 e1 rs2 e2 v ld rd rdr tr
        tbl[0]  = '{mk(1,1,1, 5,1,5,1, 1,1,5, 1,0), 9'b001010110};
        tbl[1]  = '{z,                               9'b000000000};
        tbl[2]  = '{mk(0,0,0, 0,0,5,1, 1,1,5, 0,0), 9'b110010000};
        tbl[3]  = '{mk(0,0,0, 7,1,0,0, 1,1,7, 0,0), 9'b110010000};
        tbl[4]  = '{mk(0,0,0, 0,1,0,1, 1,1,0, 0,0), 9'b000000000};
        tbl[5]  = '{mk(0,0,0, 5,0,5,0, 1,1,5, 0,0), 9'b000000000};
        tbl[6]  = '{mk(0,0,0, 5,1,5,1, 0,1,5, 0,0), 9'b000000000};
        tbl[7]  = '{mk(0,0,0, 5,1,5,1, 1,0,5, 0,0), 9'b000000000};
        tbl[8]  = '{mk(0,0,0, 0,0,0,0, 0,0,0, 1,0), 9'b001010000};
        tbl[9]  = '{mk(0,0,1, 0,0,0,0, 0,0,0, 1,0), 9'b110101010};
        tbl[10] = '{mk(0,0,1, 3,1,0,0, 1,1,3, 0,1), 9'b001010100};
        tbl[11] = '{mk(0,1,0, 0,0,0,0, 0,0,0, 0,0), 9'b101000000};
        tbl[12] = '{mk(0,0,0, 4,1,0,0, 1,1,4, 1,0), 9'b001010000};
        tbl[13] = '{mk(0,1,0, 4,1,0,0, 1,1,4, 0,0), 9'b110010000};
        tbl[14] = '{mk(0,1,1, 0,0,0,0, 0,0,0, 1,0), 9'b110101010};
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].in, 1, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Redirect deferred by a 3-cycle memory stall, then taken.
        step(mk(1,0,0, 0,0,0,0, 0,0,0, 0,0), 0, '0, "t3_rst");
        for (int i = 0; i < 3; i++)
            step(mk(0,0,1, 0,0,0,0, 0,0,0, 1,0), 1, 9'b110101010, "t3_stall");
        chk("t3_cnt3", int'(stall_cnt), 3);
        step(mk(0,0,0, 0,0,0,0, 0,0,0, 1,0), 1, 9'b001010000, "t3_redir");

        // Redirect with a fetch in flight: squash until the response lands.
        step(mk(0,1,0, 0,0,0,0, 0,0,0, 1,0), 1, 9'b001010000, "t4_entry");
        for (int i = 0; i < 2; i++)
            step(mk(0,1,0, 0,0,0,0, 0,0,0, 0,0), 1, 9'b101000001, "t4_sq");
        step(z, 1, 9'b101000001, "t4_land");
        step(z, 1, 9'b000000000, "t4_idle");

        // Trap inside SQUASH applies trap clears and keeps squashing.
        step(mk(0,1,0, 0,0,0,0, 0,0,0, 0,1), 1, 9'b001010100, "t5_trap_enter");
        step(mk(0,1,1, 0,0,0,0, 0,0,0, 0,1), 1, 9'b001010101, "t5_trap_sq");
        step(z, 1, 9'b101000001, "t5_land");

        // Counter saturation and reset.
        step(mk(1,0,0, 0,0,0,0, 0,0,0, 0,0), 0, '0, "t6_rst");
        for (int i = 0; i < CNT_MAX - 1; i++)
            step(mk(0,1,0, 0,0,0,0, 0,0,0, 0,0), 0, '0, "t6_fill");
        chk("t6_max_minus1", int'(stall_cnt), CNT_MAX - 1);
        for (int i = 0; i < 3; i++)
            step(mk(0,1,0, 0,0,0,0, 0,0,0, 0,0), 1, 9'b101000000, "t6_sat");
        chk("t6_saturated", int'(stall_cnt), CNT_MAX);
        step(mk(0,1,0, 0,0,0,0, 0,0,0, 1,0), 0, '0, "t6_sq_entry");
        step(mk(1,1,0, 0,0,0,0, 0,0,0, 0,0), 1, 9'b001010110, "t6_rst_sq");
        chk("t6_cnt_zero", int'(stall_cnt), 0);
        step(mk(0,1,0, 0,0,0,0, 0,0,0, 0,0), 1, 9'b101000000, "t6_idle_after");

        // Random traffic with small register indices to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            in_t r;
            r = mk($urandom_range(39) == 0, $urandom_range(1), $urandom_range(3) == 0,
                   int'($urandom_range(3)), $urandom_range(1),
                   int'($urandom_range(3)), $urandom_range(1),
                   $urandom_range(3) != 0, $urandom_range(1),
                   int'($urandom_range(3)), $urandom_range(4) == 0,
                   $urandom_range(11) == 0);
            step(r, 0, '0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
